// File: rtl/spi_pkg.sv
// Shared frame layout, widths and FSM encoding for the SPI slave register file.
package spi_pkg;

   localparam int unsigned FRAME_BITS = 41;
   localparam int unsigned HDR_BITS   = 9;
   localparam int unsigned WR_RD_BIT  = 40;
   localparam int unsigned CS_BIT     = 39;
   localparam int unsigned ADDR_MSB   = 38;
   localparam int unsigned ADDR_LSB   = 32;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 7;
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned ERRCNT_W   = 16;

   localparam logic [ADDR_W-1:0] ERRCNT_ADDR = 7'h7F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_DONE,
      ST_COMMIT
   } spi_state_e;

endpackage

// File: rtl/spi_slave_shifter.sv
// spi_clk edge detection, rx/tx shift registers and the received-bit counter.
module spi_slave_shifter
   import spi_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_spi_clk,
   input  logic                  i_spi_mosi,
   input  logic                  i_spi_cs_n,
   input  logic                  i_clr,
   input  logic                  i_tx_clr,
   input  logic                  i_tx_load,
   input  logic                  i_tx_shift,
   input  logic [DATA_W-1:0]     i_tx_data,
   output logic                  o_rise_c,
   output logic                  o_fall_c,
   output logic [FRAME_BITS-1:0] o_rx,
   output logic [CNT_W-1:0]      o_bit_cnt,
   output logic                  o_miso
);

   logic                  r_clk_d;
   logic [FRAME_BITS-1:0] r_rx;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [DATA_W-1:0]     r_tx;
   logic                  w_shift;
   logic [FRAME_BITS-1:0] w_rx_base;
   logic [CNT_W-1:0]      w_cnt_base;

   assign o_rise_c = i_spi_clk & ~r_clk_d;
   assign o_fall_c = ~i_spi_clk & r_clk_d;
   assign w_shift  = o_rise_c & ~i_spi_cs_n;

   // A rise landing on the same cycle as the clear still counts as bit 0.
   assign w_rx_base  = i_clr ? '0 : r_rx;
   assign w_cnt_base = i_clr ? '0 : r_bit_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_clk_d   <= 1'b0;
         r_rx      <= '0;
         r_bit_cnt <= '0;
         r_tx      <= '0;
      end else begin
         r_clk_d <= i_spi_clk;
         if (w_shift) begin
            r_rx      <= {w_rx_base[FRAME_BITS-2:0], i_spi_mosi};
            r_bit_cnt <= (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
         end else begin
            r_rx      <= w_rx_base;
            r_bit_cnt <= w_cnt_base;
         end
         if (i_tx_clr)
            r_tx <= '0;
         else if (i_tx_load)
            r_tx <= i_tx_data;
         else if (i_tx_shift)
            r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end
   end

   assign o_rx      = r_rx;
   assign o_bit_cnt = r_bit_cnt;
   assign o_miso    = r_tx[DATA_W-1];

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave endpoint for 41-bit frames backed by a DEPTH x 32-bit register file.
// Define SPI_SLAVE_ERRCNT_EN to add a saturating frame-error counter at ERRCNT_ADDR.
module spi_slave_regfile
   import spi_pkg::*;
#(
   parameter int unsigned CS_ID = 0,
   parameter int unsigned DEPTH = 16
)(
   input  logic                    SCLK,
   input  logic                    SRESET,
   input  logic                    spi_clk,
   input  logic                    spi_mosi,
   input  logic                    spi_cs_n,
   output logic                    spi_miso,
   output logic [DEPTH*DATA_W-1:0] reg_q,
   output logic                    wr_strobe,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [DATA_W-1:0]       wr_data,
   output logic                    frame_err
);

   spi_state_e              r_state;
   logic                    r_first;
   logic                    r_over;
   logic [DEPTH*DATA_W-1:0] r_reg_q;
   logic                    r_wr_strobe;
   logic [ADDR_W-1:0]       r_wr_addr;
   logic [DATA_W-1:0]       r_wr_data;
   logic                    r_frame_err;

   logic                  w_rise, w_fall, w_clr, w_miso;
   logic                  w_tx_clr, w_tx_load, w_tx_shift, w_leave_data;
   logic [FRAME_BITS-1:0] w_rx;
   logic [CNT_W-1:0]      w_bit_cnt;
   logic [DATA_W-1:0]     w_rd_data, w_tx_data;
   logic [ADDR_W-1:0]     w_fr_addr;
   logic [DATA_W-1:0]     w_fr_data;
   logic                  w_frame_ok, w_is_cnt, w_wr_ok;

   spi_slave_shifter u_shifter (
      .i_clk      (SCLK),
      .i_rst      (SRESET),
      .i_spi_clk  (spi_clk),
      .i_spi_mosi (spi_mosi),
      .i_spi_cs_n (spi_cs_n),
      .i_clr      (w_clr),
      .i_tx_clr   (w_tx_clr),
      .i_tx_load  (w_tx_load),
      .i_tx_shift (w_tx_shift),
      .i_tx_data  (w_tx_data),
      .o_rise_c   (w_rise),
      .o_fall_c   (w_fall),
      .o_rx       (w_rx),
      .o_bit_cnt  (w_bit_cnt),
      .o_miso     (w_miso)
   );

`ifdef SPI_SLAVE_ERRCNT_EN
   logic [ERRCNT_W-1:0] r_err_cnt;
   assign w_is_cnt = (w_fr_addr == ERRCNT_ADDR);
`else
   assign w_is_cnt = 1'b0;
`endif

   // Header sits in rx[8:0] at the first DATA fall: rx[8] = wr_rd, rx[6:0] = addr.
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < DEPTH; i++)
         if (w_rx[ADDR_W-1:0] == ADDR_W'(i))
            w_rd_data = r_reg_q[DATA_W*i +: DATA_W];
`ifdef SPI_SLAVE_ERRCNT_EN
      if (w_rx[ADDR_W-1:0] == ERRCNT_ADDR)
         w_rd_data = {{(DATA_W-ERRCNT_W){1'b0}}, r_err_cnt};
`endif
   end

   assign w_tx_data    = w_rx[HDR_BITS-1] ? '0 : w_rd_data;
   assign w_clr        = (r_state == ST_IDLE) & ~spi_cs_n;
   assign w_leave_data = spi_cs_n | (w_rise & (w_bit_cnt == CNT_W'(FRAME_BITS-1)));
   assign w_tx_clr     = (r_state != ST_DATA) | w_leave_data;
   assign w_tx_load    = (r_state == ST_DATA) & w_fall & r_first;
   assign w_tx_shift   = (r_state == ST_DATA) & w_fall & ~r_first;

   assign w_fr_addr  = w_rx[ADDR_MSB:ADDR_LSB];
   assign w_fr_data  = w_rx[DATA_W-1:0];
   assign w_frame_ok = ~r_over & (w_bit_cnt == CNT_W'(FRAME_BITS));
   assign w_wr_ok    = (w_rx[CS_BIT] == 1'(CS_ID)) &
                       ((w_fr_addr < ADDR_W'(DEPTH)) | w_is_cnt);

   always_ff @(posedge SCLK or posedge SRESET) begin
      if (SRESET) begin
         r_state     <= ST_IDLE;
         r_first     <= 1'b0;
         r_over      <= 1'b0;
         r_reg_q     <= '0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!spi_cs_n) begin
                  r_over  <= 1'b0;
                  r_state <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (spi_cs_n) begin
                  r_frame_err <= 1'b1;
                  r_state     <= ST_IDLE;
               end else if (w_rise && w_bit_cnt == CNT_W'(HDR_BITS-1)) begin
                  r_first <= 1'b1;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (spi_cs_n) begin
                  r_frame_err <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  if (w_fall)
                     r_first <= 1'b0;
                  if (w_rise && w_bit_cnt == CNT_W'(FRAME_BITS-1))
                     r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (w_rise && !spi_cs_n)
                  r_over <= 1'b1;
               if (spi_cs_n)
                  r_state <= ST_COMMIT;
            end
            ST_COMMIT: begin
               r_state <= ST_IDLE;
               if (!w_frame_ok) begin
                  r_frame_err <= 1'b1;
               end else if (w_rx[WR_RD_BIT]) begin
                  if (w_wr_ok) begin
                     r_wr_strobe <= 1'b1;
                     r_wr_addr   <= w_fr_addr;
                     r_wr_data   <= w_fr_data;
                     for (int i = 0; i < DEPTH; i++)
                        if (w_fr_addr == ADDR_W'(i))
                           r_reg_q[DATA_W*i +: DATA_W] <= w_fr_data;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SPI_SLAVE_ERRCNT_EN
   // Counts each frame_err pulse the cycle after it; a committed write to ERRCNT_ADDR clears it.
   always_ff @(posedge SCLK or posedge SRESET) begin
      if (SRESET)
         r_err_cnt <= '0;
      else if (r_state == ST_COMMIT && w_frame_ok && w_rx[WR_RD_BIT] && w_wr_ok && w_is_cnt)
         r_err_cnt <= '0;
      else if (r_frame_err && !(&r_err_cnt))
         r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
   end
`endif

   assign spi_miso  = w_miso;
   assign reg_q     = r_reg_q;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: a cycle-accurate SPI master task drives
// 41-bit frames and the results are compared against hand-computed values.
module tb_spi_slave_regfile;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned QW    = DEPTH * 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          spi_clk, spi_mosi, spi_cs_n;
   logic          spi_miso;
   logic [QW-1:0] reg_q;
   logic          wr_strobe;
   logic [6:0]    wr_addr;
   logic [31:0]   wr_data;
   logic          frame_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_wr    = 0;
   int          n_err   = 0;
   logic [6:0]  last_addr = '0;
   logic [31:0] last_data = '0;
   int          exp_wr  = 0;
   int          exp_err = 0;
   int          exp_cnt = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] rd;

   spi_slave_regfile #(.CS_ID(0), .DEPTH(DEPTH)) dut (
      .SCLK      (clk),
      .SRESET    (rst),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .spi_cs_n  (spi_cs_n),
      .spi_miso  (spi_miso),
      .reg_q     (reg_q),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_strobe) begin
         n_wr++;
         last_addr = wr_addr;
         last_data = wr_data;
      end
      if (frame_err) n_err++;
   end

   task automatic check_eq(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [QW-1:0] model_flat();
      logic [QW-1:0] v;
      v = '0;
      for (int i = 0; i < DEPTH; i++) v[32*i +: 32] = model[i];
      return v;
   endfunction

   function automatic logic [40:0] mk(input logic wr, input logic cs, input logic [6:0] a, input logic [31:0] d);
      return {wr, cs, a, d};
   endfunction

   // Master: LOAD (cs low), then per bit edge A raises spi_clk/sets MOSI, edge B lowers it.
   // The last edge B also raises cs_n.
   task automatic spi_xfer(input logic [40:0] frame, input int nbits, input int idle, output logic [31:0] rdata);
      rdata = '0;
      @(posedge clk); #1 spi_cs_n = 1'b0;
      @(posedge clk);
      for (int k = 0; k < nbits; k++) begin
         @(posedge clk); #1 spi_clk = 1'b1;
         if (k < 41) spi_mosi = frame[40-k];
         else        spi_mosi = 1'b0;
         @(negedge clk);
         if (k >= 9 && k <= 40) rdata[40-k] = spi_miso;
         @(posedge clk); #1 spi_clk = 1'b0;
         if (k == nbits-1) spi_cs_n = 1'b1;
      end
      repeat (idle) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_miso",   QW'(spi_miso),  '0);
      check_eq("rst_reg_q",  reg_q,          '0);
      check_eq("rst_wr_stb", QW'(wr_strobe), '0);
      check_eq("rst_wr_adr", QW'(wr_addr),   '0);
      check_eq("rst_wr_dat", QW'(wr_data),   '0);
      check_eq("rst_ferr",   QW'(frame_err), '0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Plain write then read of reg 3
      spi_xfer(mk(1'b1, 1'b0, 7'h03, 32'hDEADBEEF), 41, 3, rd);
      model[3] = 32'hDEADBEEF; exp_wr++;
      check_eq("wr3_count", QW'(n_wr),      QW'(exp_wr));
      check_eq("wr3_addr",  QW'(last_addr), QW'(7'h03));
      check_eq("wr3_data",  QW'(last_data), QW'(32'hDEADBEEF));
      check_eq("wr3_regq",  reg_q,          model_flat());
      check_eq("wr3_miso0", QW'(rd),        '0);
      check_eq("wr3_noerr", QW'(n_err),     QW'(exp_err));

      spi_xfer(mk(1'b0, 1'b0, 7'h03, 32'h0), 41, 3, rd);
      check_eq("rd3_data",  QW'(rd),   QW'(32'hDEADBEEF));
      check_eq("rd3_nowr",  QW'(n_wr), QW'(exp_wr));

      // Out-of-range address
      spi_xfer(mk(1'b0, 1'b0, 7'h20, 32'h0), 41, 3, rd);
      check_eq("rd20_data",  QW'(rd),    '0);
      check_eq("rd20_noerr", QW'(n_err), QW'(exp_err));
      spi_xfer(mk(1'b1, 1'b0, 7'h20, 32'h55AA55AA), 41, 3, rd);
      exp_err++; exp_cnt++;
      check_eq("wr20_err",  QW'(n_err), QW'(exp_err));
      check_eq("wr20_nowr", QW'(n_wr),  QW'(exp_wr));
      check_eq("wr20_regq", reg_q,      model_flat());

      // Abort after 20 bits of a write
      spi_xfer(mk(1'b1, 1'b0, 7'h02, 32'hCAFEF00D), 20, 3, rd);
      exp_err++; exp_cnt++;
      check_eq("abort_err",  QW'(n_err), QW'(exp_err));
      check_eq("abort_nowr", QW'(n_wr),  QW'(exp_wr));
      check_eq("abort_regq", reg_q,      model_flat());

      // Back-to-back write then read of reg 1
      spi_xfer(mk(1'b1, 1'b0, 7'h01, 32'h12345678), 41, 0, rd);
      spi_xfer(mk(1'b0, 1'b0, 7'h01, 32'h0), 41, 3, rd);
      model[1] = 32'h12345678; exp_wr++;
      check_eq("b2b_rd",    QW'(rd),        QW'(32'h12345678));
      check_eq("b2b_count", QW'(n_wr),      QW'(exp_wr));
      check_eq("b2b_addr",  QW'(last_addr), QW'(7'h01));
      check_eq("b2b_regq",  reg_q,          model_flat());

      // Write addressed to the other chip select
      spi_xfer(mk(1'b1, 1'b1, 7'h04, 32'h11112222), 41, 3, rd);
      exp_err++; exp_cnt++;
      check_eq("cs1_err",  QW'(n_err), QW'(exp_err));
      check_eq("cs1_regq", reg_q,      model_flat());

      // Over-length (42-bit) write
      spi_xfer(mk(1'b1, 1'b0, 7'h06, 32'h66666666), 42, 3, rd);
      exp_err++; exp_cnt++;
      check_eq("long_err",  QW'(n_err), QW'(exp_err));
      check_eq("long_nowr", QW'(n_wr),  QW'(exp_wr));
      check_eq("long_regq", reg_q,      model_flat());

      // Last register
      spi_xfer(mk(1'b1, 1'b0, 7'h0F, 32'hA5A55A5A), 41, 0, rd);
      spi_xfer(mk(1'b0, 1'b0, 7'h0F, 32'h0), 41, 3, rd);
      model[15] = 32'hA5A55A5A; exp_wr++;
      check_eq("r15_rd",   QW'(rd),   QW'(32'hA5A55A5A));
      check_eq("r15_regq", reg_q,     model_flat());
      check_eq("r15_cnt",  QW'(n_wr), QW'(exp_wr));

`ifdef SPI_SLAVE_ERRCNT_EN
      spi_xfer(mk(1'b0, 1'b0, 7'h7F, 32'h0), 41, 3, rd);
      check_eq("ecnt_rd", QW'(rd), QW'(exp_cnt));
      spi_xfer(mk(1'b1, 1'b0, 7'h7F, 32'h00000000), 41, 3, rd);
      exp_wr++; exp_cnt = 0;
      check_eq("ecnt_clr_stb",  QW'(n_wr),      QW'(exp_wr));
      check_eq("ecnt_clr_addr", QW'(last_addr), QW'(7'h7F));
      spi_xfer(mk(1'b0, 1'b0, 7'h7F, 32'h0), 41, 3, rd);
      check_eq("ecnt_rd0", QW'(rd), QW'(exp_cnt));
      spi_xfer(mk(1'b1, 1'b0, 7'h02, 32'h0), 12, 3, rd);
      spi_xfer(mk(1'b1, 1'b0, 7'h02, 32'h0), 30, 3, rd);
      exp_err += 2; exp_cnt += 2;
      spi_xfer(mk(1'b0, 1'b0, 7'h7F, 32'h0), 41, 3, rd);
      check_eq("ecnt_rd2", QW'(rd),    QW'(exp_cnt));
      check_eq("ecnt_err", QW'(n_err), QW'(exp_err));
`else
      spi_xfer(mk(1'b0, 1'b0, 7'h7F, 32'h0), 41, 3, rd);
      check_eq("r7f_rd", QW'(rd), '0);
      spi_xfer(mk(1'b1, 1'b0, 7'h7F, 32'h0), 41, 3, rd);
      exp_err++;
      check_eq("w7f_err",  QW'(n_err), QW'(exp_err));
      check_eq("w7f_nowr", QW'(n_wr),  QW'(exp_wr));
`endif

      // Reset in the middle of a frame
      @(posedge clk); #1 spi_cs_n = 1'b0;
      repeat (6) begin
         @(posedge clk); #1 spi_clk = 1'b1; spi_mosi = 1'b1;
         @(posedge clk); #1 spi_clk = 1'b0;
      end
      rst = 1'b1;
      #2;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      check_eq("mid_rst_regq", reg_q,        model_flat());
      check_eq("mid_rst_data", QW'(wr_data), '0);
      check_eq("mid_rst_addr", QW'(wr_addr), '0);
      check_eq("mid_rst_miso", QW'(spi_miso), '0);
      spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      spi_xfer(mk(1'b1, 1'b0, 7'h05, 32'h0BADF00D), 41, 0, rd);
      spi_xfer(mk(1'b0, 1'b0, 7'h05, 32'h0), 41, 3, rd);
      model[5] = 32'h0BADF00D; exp_wr++;
      check_eq("post_rst_rd",   QW'(rd),   QW'(32'h0BADF00D));
      check_eq("post_rst_regq", reg_q,     model_flat());
      check_eq("post_rst_cnt",  QW'(n_wr), QW'(exp_wr));
      check_eq("post_rst_err",  QW'(n_err), QW'(exp_err));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

SPI slave endpoint that terminates the 41-bit frames issued by the team's SPI master and backs them with a local 32-bit register file. It sits on the peripheral side of the AHB-Lite-to-SPI bridge, one instance per chip select. Write frames update a register; read frames return register contents on MISO in the exact bit slots the master samples. It runs in the master's SCLK domain, so spi_clk is edge-detected synchronously, without synchronizers.

## Interface
- CS_ID, 0: value of frame bit 39 this instance answers to (0 → wired to spi_cs0, 1 → spi_cs1).
- DEPTH, 16: number of 32-bit registers, addresses 0..DEPTH-1, DEPTH ≤ 127.
- SCLK  in  1  system clock, shared with master; all logic on posedge.
- SRESET  in  1  reset, asynchronous, active-high.
- spi_clk  in  1  SPI clock from master; idle low; each half-period is one SCLK.
- spi_mosi  in  1  serial data from master, MSB (bit 40) first.
- spi_cs_n  in  1  chip select, active low.
- spi_miso  out  1  serial read data to master.
- reg_q  out  DEPTH*32  flattened register file, register i at [32*i+31:32*i].
- wr_strobe  out  1  one-cycle pulse on committed write.
- wr_addr  out  7  address of committed write.
- wr_data  out  32  data of committed write.
- frame_err  out  1  one-cycle pulse on aborted or malformed frame.

## Operation
- Frame format (bit 40 first): [40] wr_rd (1 write, 0 read), [39] chip_sel, [38:32] addr, [31:0] data.
- clk_d registers spi_clk each cycle. rise = spi_clk & ~clk_d; fall = ~spi_clk & clk_d.
- On rise with spi_cs_n low: shift spi_mosi into a 41-bit rx shift register and increment bit_cnt (6 bits, saturating at 63).
- States:
  - IDLE: wait for spi_cs_n low, then clear bit_cnt and rx shift register and go to HDR.
  - HDR: bits 0..8. After the rise that makes bit_cnt 9, go to DATA.
  - DATA: on each fall, drive the next MISO bit. After the rise that makes bit_cnt 41, go to DONE.
  - DONE: wait for spi_cs_n high, then go to COMMIT.
  - COMMIT: one cycle, then IDLE.
- spi_cs_n high in HDR or DATA: frame_err pulse, no write, go to IDLE.
- A rise in DONE (more than 41 bits): frame_err pulse at COMMIT, no write.
- Read path:
  - On the first fall in DATA, load a 32-bit tx shift register with reg[addr] (0 if addr ≥ DEPTH) and drive spi_miso = bit 31.
  - Each later fall shifts left and drives the next bit.
  - The snapshot keeps the read coherent even if a write commits mid-frame.
- Write path, in COMMIT:
  - Condition: wr_rd=1, chip_sel==CS_ID, addr<DEPTH, exactly 41 bits received.
  - Action: reg[addr] <= data, wr_strobe=1, wr_addr/wr_data driven.
  - addr ≥ DEPTH, or chip_sel≠CS_ID: frame_err pulse, no write.
- spi_miso is 0 whenever not in DATA or the frame is a write. It is never tri-stated.

## Timing
- Reset values: spi_miso 0, reg_q 0, wr_strobe 0, wr_addr 0, wr_data 0, frame_err 0. State is IDLE, clk_d is 0.
- Master bit k: cycle A raises spi_clk and sets MOSI; cycle B lowers spi_clk and samples MISO. The slave sees the rise in cycle B and the fall in cycle A of bit k+1.
- MISO bit 31 is driven at cycle A of bit 9 and sampled at cycle B of bit 9. MISO has one full SCLK of setup per bit.
- Write latency: wr_strobe and reg_q update 2 SCLK after the master's final edge. That final edge lowers spi_clk and raises spi_cs_n together.
- Back-to-back frames: the master spends at least 2 cycles in IDLE/LOAD, which is enough for COMMIT→IDLE.
- SRESET mid-frame: everything returns to reset values and the register file is cleared.

## Configuration
- SPI_SLAVE_ERRCNT_EN defined:
  - Adds a 16-bit saturating counter of frame_err pulses.
  - Reads at addr 7'h7F return {16'd0, count}.
  - A write to 7'h7F clears the counter and pulses wr_strobe.
  - Reset value is 0.
- Undefined: there is no counter, and 7'h7F behaves as any out-of-range address.

## Structure
- Shared package spi_pkg holds:
  - Frame bit positions WR_RD_BIT=40, CS_BIT=39, ADDR_MSB=38, ADDR_LSB=32.
  - FRAME_BITS=41.
  - ERRCNT_ADDR=7'h7F.
  - The state encoding for IDLE/HDR/DATA/DONE/COMMIT.
- One natural sub-module: spi_slave_shifter, holding edge detect, rx/tx shift registers and bit_cnt. The FSM and register file stay in the top module.

## Test plan
- Write frame {1,0,7'h03,32'hDEADBEEF}, CS_ID=0: wr_strobe pulses once with wr_addr 3 and wr_data DEADBEEF; reg 3 reads DEADBEEF.
- After that write, read frame {0,0,7'h03,32'h0}: the master's Rx_FIFO receives 32'hDEADBEEF.
- Read of addr 7'h20 with DEPTH=16: the master receives 0. A write to 7'h20 gives a frame_err pulse and reg_q unchanged.
- Master deasserts spi_cs_n after 20 bits of a write: frame_err pulses, no wr_strobe, and the next full frame works normally.
- Back-to-back write reg 1 = 1234_5678, then read reg 1: read returns 12345678 with no idle gap beyond the master's own.
- With SPI_SLAVE_ERRCNT_EN, two aborted frames then a read of 7'h7F returns 2. A write to 7'h7F then a read returns 0.
